// File: rtl/lut_frac_chain_cfg_pkg.sv
// Shared constants, FSM state type and image index helpers for the chainable
// fracturable LUT cluster and its configuration loader.
package lut_frac_chain_cfg_pkg;

    localparam int DEF_INPUTS = 4;
    localparam int DEF_LUTS   = 2;
    localparam int DEF_CFG_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMMIT,
        ST_READ
    } state_t;

    function automatic int lut_m(input int inputs);
        return 1 << inputs;
    endfunction

    function automatic int cfg_bits(input int inputs, input int luts);
        return luts * lut_m(inputs) + (luts - 1);
    endfunction

    function automatic int chunk_count(input int inputs, input int luts, input int cfg_w);
        return (cfg_bits(inputs, luts) + cfg_w - 1) / cfg_w;
    endfunction

    // Truth table k starts here in the image; chain bits follow all tables.
    function automatic int table_base(input int k, input int inputs);
        return k * lut_m(inputs);
    endfunction

    function automatic int chain_index(input int j, input int inputs, input int luts);
        return luts * lut_m(inputs) + j;
    endfunction

    localparam int DEF_M        = lut_m(DEF_INPUTS);
    localparam int DEF_CFG_BITS = cfg_bits(DEF_INPUTS, DEF_LUTS);
    localparam int DEF_CHUNKS   = chunk_count(DEF_INPUTS, DEF_LUTS, DEF_CFG_W);

endpackage

// File: rtl/lut_frac_cell.sv
// One fracturable sub-LUT: a 2^INPUTS-bit table split into lower and upper
// halves, with the full output chosen by an externally supplied MSB.
module lut_frac_cell
    import lut_frac_chain_cfg_pkg::*;
#(
    parameter int INPUTS = DEF_INPUTS
) (
    input  logic [lut_m(INPUTS)-1:0] table_bits,
    input  logic [INPUTS-2:0]        sel,
    input  logic                     msb,
    output logic                     out_lo,
    output logic                     out_hi,
    output logic                     out_full
);

    localparam int HALF = lut_m(INPUTS) / 2;

    logic [HALF-1:0] lo_half;
    logic [HALF-1:0] hi_half;

    assign lo_half  = table_bits[HALF-1:0];
    assign hi_half  = table_bits[2*HALF-1:HALF];
    assign out_lo   = lo_half[sel];
    assign out_hi   = hi_half[sel];
    assign out_full = msb ? out_hi : out_lo;

endmodule

// File: rtl/lut_frac_chain_cfg.sv
// Chainable fracturable LUT cluster with a streaming shadow-image loader,
// atomic commit and readback of the active image.
module lut_frac_chain_cfg
    import lut_frac_chain_cfg_pkg::*;
#(
    parameter int INPUTS = DEF_INPUTS,
    parameter int LUTS   = DEF_LUTS,
    parameter int CFG_W  = DEF_CFG_W
) (
    input  logic                     cclk,
    input  logic                     rst,
    input  logic [LUTS*INPUTS-1:0]   addr,
    output logic [LUTS-1:0]          out_full,
    output logic [LUTS-1:0]          out_lo,
    output logic [LUTS-1:0]          out_hi,
    input  logic                     cfg_start,
    input  logic                     cfg_valid,
    input  logic [CFG_W-1:0]         cfg_data,
    output logic                     cfg_ready,
    output logic                     cfg_done,
    input  logic                     rb_start,
    output logic                     rb_valid,
    output logic [CFG_W-1:0]         rb_data,
    input  logic                     rb_ready,
    output logic                     busy
);

    localparam int M        = lut_m(INPUTS);
    localparam int CFG_BITS = cfg_bits(INPUTS, LUTS);
    localparam int CHUNKS   = chunk_count(INPUTS, LUTS, CFG_W);
    localparam int IMG_W    = CHUNKS * CFG_W;
    localparam int CNT_W    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IMG_W-1:0] IMG_MASK = ~({IMG_W{1'b1}} << CFG_BITS);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [IMG_W-1:0]   shadow_img;
    logic [IMG_W-1:0]   active_img;
    logic               done_q;
    logic               last_chunk;
    logic               cfg_accept;
    logic               rb_accept;

    assign last_chunk = (cnt == CNT_W'(CHUNKS - 1));
    assign cfg_accept = (state == ST_LOAD) && cfg_valid;
    assign rb_accept  = (state == ST_READ) && rb_ready;

    // NOTE: state and datapath registers use <= so every flop samples pre-edge values.
    always_ff @(posedge cclk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (cfg_start)     state_next = ST_LOAD;
                else if (rb_start) state_next = ST_READ;
            end
            ST_LOAD:   if (cfg_accept && last_chunk) state_next = ST_COMMIT;
            ST_COMMIT: state_next = ST_IDLE;
            ST_READ:   if (rb_accept && last_chunk) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (state == ST_LOAD);
        rb_valid  = (state == ST_READ);
        busy      = (state != ST_IDLE);
        rb_data   = '0;
        if (state == ST_READ) rb_data = active_img[cnt*CFG_W +: CFG_W];
    end

    assign cfg_done = done_q;

    // NOTE: both image registers are reset because a reset mid-load must leave a zero image.
    always_ff @(posedge cclk) begin
        if (rst) begin
            cnt        <= '0;
            shadow_img <= '0;
            active_img <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state == ST_COMMIT);
            if (state == ST_IDLE)             cnt <= '0;
            else if (cfg_accept || rb_accept) cnt <= last_chunk ? '0 : cnt + 1'b1;
            if (cfg_accept) shadow_img[cnt*CFG_W +: CFG_W] <= cfg_data;
            // Padding above CFG_BITS is dropped here so readback returns zeros.
            if (state == ST_COMMIT) active_img <= shadow_img & IMG_MASK;
        end
    end

    for (genvar k = 0; k < LUTS; k++) begin : g_lut
        logic [INPUTS-1:0] a;
        logic              msb;
        logic              full;

        assign a = addr[k*INPUTS +: INPUTS];

        if (k == 0) begin : g_base
            assign msb = a[INPUTS-1];
        end else begin : g_chain
            assign msb = active_img[chain_index(k - 1, INPUTS, LUTS)] ? g_lut[k-1].full : a[INPUTS-1];
        end

        lut_frac_cell #(.INPUTS(INPUTS)) u_cell (
            .table_bits (active_img[table_base(k, INPUTS) +: M]),
            .sel        (a[INPUTS-2:0]),
            .msb        (msb),
            .out_lo     (out_lo[k]),
            .out_hi     (out_hi[k]),
            .out_full   (full)
        );

        assign out_full[k] = full;
    end

endmodule

// File: tb/tb_lut_frac_chain_cfg.sv
// Directed bench for lut_frac_chain_cfg: loads, chaining, fracturing,
// atomic commit, reset abort and scoreboarded readback with random backpressure.
module tb_lut_frac_chain_cfg;

    localparam int INPUTS   = 4;
    localparam int LUTS     = 2;
    localparam int CFG_W    = 8;
    localparam int CHUNKS   = 5;
    localparam int IMG_W    = 40;
    localparam int CFG_BITS = 33;

    logic                   cclk = 1'b0;
    logic                   rst;
    logic [LUTS*INPUTS-1:0] addr;
    logic [LUTS-1:0]        out_full;
    logic [LUTS-1:0]        out_lo;
    logic [LUTS-1:0]        out_hi;
    logic                   cfg_start;
    logic                   cfg_valid;
    logic [CFG_W-1:0]       cfg_data;
    logic                   cfg_ready;
    logic                   cfg_done;
    logic                   rb_start;
    logic                   rb_valid;
    logic [CFG_W-1:0]       rb_data;
    logic                   rb_ready;
    logic                   busy;

    int checks   = 0;
    int failures = 0;
    logic [CFG_W-1:0] rb_queue[$];

    lut_frac_chain_cfg #(.INPUTS(INPUTS), .LUTS(LUTS), .CFG_W(CFG_W)) dut (
        .cclk      (cclk),
        .rst       (rst),
        .addr      (addr),
        .out_full  (out_full),
        .out_lo    (out_lo),
        .out_hi    (out_hi),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .rb_start  (rb_start),
        .rb_valid  (rb_valid),
        .rb_data   (rb_data),
        .rb_ready  (rb_ready),
        .busy      (busy)
    );

    always #5 cclk = ~cclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge cclk);
        #1;
    endtask

    // Reference LUT behaviour: returns {hi, lo, full}.
    function automatic logic [5:0] model(input logic [IMG_W-1:0] img, input logic [7:0] a);
        logic [1:0]  full;
        logic [1:0]  lo;
        logic [1:0]  hi;
        logic [15:0] t;
        logic [3:0]  ak;
        logic        msb;
        full = '0;
        for (int k = 0; k < 2; k++) begin
            t     = img[k*16 +: 16];
            ak    = a[k*4 +: 4];
            lo[k] = t[{1'b0, ak[2:0]}];
            hi[k] = t[{1'b1, ak[2:0]}];
            msb   = ak[3];
            if (k == 1 && img[32]) msb = full[0];
            full[k] = msb ? hi[k] : lo[k];
        end
        return {hi, lo, full};
    endfunction

    task automatic check_lut(input string tag, input logic [IMG_W-1:0] img, input logic [7:0] a);
        logic [5:0] e;
        addr = a;
        #1;
        e = model(img, a);
        check({tag, "_full"}, out_full, e[1:0]);
        check({tag, "_lo"},   out_lo,   e[3:2]);
        check({tag, "_hi"},   out_hi,   e[5:4]);
    endtask

    task automatic load_image(input logic [IMG_W-1:0] img, input logic with_rb);
        cfg_start = 1'b1;
        rb_start  = with_rb;
        tick();
        cfg_start = 1'b0;
        rb_start  = 1'b0;
        check("load_ready", cfg_ready, 1);
        check("load_busy", busy, 1);
        if (with_rb) check("load_wins_rb_valid", rb_valid, 0);
        for (int i = 0; i < CHUNKS; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = img[i*CFG_W +: CFG_W];
            tick();
        end
        cfg_valid = 1'b0;
        cfg_data  = '0;
        check("commit_ready", cfg_ready, 0);
        check("commit_done_low", cfg_done, 0);
        tick();
        check("cfg_done", cfg_done, 1);
        check("idle_busy", busy, 0);
        tick();
        check("cfg_done_pulse", cfg_done, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [IMG_W-1:0] img_a;
        logic [IMG_W-1:0] img_c;
        logic [IMG_W-1:0] img_f;
        logic [IMG_W-1:0] img_p;
        logic [IMG_W-1:0] mask;
        logic [IMG_W-1:0] img_pm;
        logic [3:0]       a0;
        logic [3:0]       a1;
        int               guard;

        img_a  = 40'h00_80_00_69_96;
        img_c  = 40'h01_FF_00_69_96;
        img_f  = 40'h00_00_00_00_F0;
        img_p  = 40'hFE_80_00_69_96;
        mask   = (40'h1 << CFG_BITS) - 40'h1;
        img_pm = img_p & mask;

        rst = 1'b1; addr = '0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        rb_start = 1'b0; rb_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        check("rst_busy", busy, 0);
        check("rst_rb_valid", rb_valid, 0);
        check("rst_rb_data", rb_data, 0);
        check("rst_cfg_ready", cfg_ready, 0);
        check("rst_cfg_done", cfg_done, 0);
        for (int i = 0; i < 6; i++) check_lut("rst_sweep", '0, 8'($urandom));

        // Load A with rb_start raised alongside cfg_start: the load must win.
        load_image(img_a, 1'b1);
        addr = {4'hF, 4'h7};
        #1;
        check("a_full_f7", out_full, 2'b11);
        addr = {4'hE, 4'h7};
        #1;
        check("a_full_e7", out_full, 2'b01);
        for (int i = 0; i < 8; i++) check_lut("a_sweep", img_a, 8'($urandom));

        // Chain: full1 follows full0 (XOR of addr0) whatever addr1 holds.
        load_image(img_c, 1'b0);
        for (int i = 0; i < 16; i++) begin
            a0   = 4'(i);
            a1   = 4'($urandom);
            addr = {a1, a0};
            #1;
            check("chain_full", out_full, {2{^a0}});
        end

        // Fracture: lower half selected by addr0[2:0], MSB picks the half.
        load_image(img_f, 1'b0);
        addr = {4'h0, 4'h4};
        #1;
        check("frac4_lo", out_lo, 2'b01);
        check("frac4_hi", out_hi, 2'b00);
        check("frac4_full", out_full, 2'b01);
        addr = {4'h0, 4'hC};
        #1;
        check("fracc_lo", out_lo, 2'b01);
        check("fracc_hi", out_hi, 2'b00);
        check("fracc_full", out_full, 2'b00);

        // Atomicity: a stalled partial load of the chain image leaves A active.
        load_image(img_a, 1'b0);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = img_c[i*CFG_W +: CFG_W];
            tick();
        end
        cfg_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("stall_busy", busy, 1);
            check("stall_ready", cfg_ready, 1);
            check_lut("stall_keep_a", img_a, 8'($urandom));
            tick();
        end

        // Reset mid-load discards the shadow and clears the active image.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ready", cfg_ready, 0);
        for (int i = 0; i < 4; i++) check_lut("abort_zero", '0, 8'($urandom));
        tick();

        // Padding bits in chunk 4 are ignored on load.
        load_image(img_p, 1'b0);
        for (int i = 0; i < 6; i++) check_lut("pad_ignored", img_a, 8'($urandom));

        // Readback with random backpressure against a scoreboard of A's chunks.
        for (int i = 0; i < CHUNKS; i++) rb_queue.push_back(img_pm[i*CFG_W +: CFG_W]);
        rb_start = 1'b1;
        tick();
        rb_start = 1'b0;
        check("rb_first_busy", busy, 1);
        guard = 0;
        while (rb_queue.size() != 0 && guard < 200) begin
            rb_ready = 1'($urandom_range(0, 1));
            #1;
            check("rb_valid", rb_valid, 1);
            if (rb_ready) check("rb_data", rb_data, rb_queue.pop_front());
            else          check("rb_hold", rb_data, rb_queue[0]);
            guard++;
            tick();
        end
        rb_ready = 1'b0;
        check("rb_drained", rb_queue.size(), 0);
        check("rb_end_busy", busy, 0);
        check("rb_end_valid", rb_valid, 0);
        check("rb_end_data", rb_data, 0);
        for (int i = 0; i < 4; i++) check_lut("rb_keep_a", img_a, 8'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
